rgb565_byte_packer: RTL and testbench
=====================================

Name: rgb565_byte_packer

Overview:
- Assembles a byte stream into 16-bit RGB565 pixels, i.e. the packed union's byte-pair view.
- Each pixel is presented both as a raw 16-bit word and as decoded r/g/b fields.
- Sits directly upstream of the union-typed pixel consumer: bytes come in, 16-bit union-compatible words go out.
- Valid/ready on both sides; one-entry registered output; line column tracking and packet-end handling.

Parameters:
- BYTE_ORDER, 0: 0 = first byte of a pair goes to bits [7:0]; 1 = first byte goes to bits [15:8].
- LINE_PIXELS, 640: pixels per line, used for column count and end-of-line flag (>=2).
- COL_W, $clog2(LINE_PIXELS): column counter width (derived, do not override).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_data  in  8  byte
- in_last  in  1  last byte of packet
- in_valid  in  1  byte valid
- in_ready  out  1  byte accepted when in_valid && in_ready
- out_data  out  16  assembled pixel word, r=[15:11], g=[10:5], b=[4:0]
- out_r  out  5  out_data[15:11]
- out_g  out  6  out_data[10:5]
- out_b  out  5  out_data[4:0]
- out_col  out  COL_W  column index of presented pixel
- out_eol  out  1  presented pixel is column LINE_PIXELS-1
- out_last  out  1  presented pixel ends a packet
- out_valid  out  1  pixel valid
- out_ready  in  1  pixel consumed when out_valid && out_ready
- err_odd  out  1  sticky: packet ended on an odd byte
- err_clr  in  1  synchronous clear of err_odd

Behaviour:
- Reset (async assert, sync release):
  - State FIRST.
  - out_valid=0; out_data, out_col, out_eol, out_last = 0.
  - err_odd=0; internal column counter = 0.
  - A reset mid-pair discards the held byte.
- space = !out_valid || out_ready.
- State FIRST:
  - in_ready=1.
  - Accepted byte is stored in a holding register.
  - in_last=0 -> SECOND.
  - in_last=1 -> FLUSH.
- State SECOND:
  - in_ready=space.
  - On accept, the output register loads {byte,held} (BYTE_ORDER=0) or {held,byte} (BYTE_ORDER=1).
  - out_last=in_last; out_valid=1; -> FIRST.
- State FLUSH:
  - in_ready=0.
  - When space, the output loads the held byte with the missing byte as 0x00, placed per BYTE_ORDER.
  - out_last=1; err_odd set; -> FIRST.
- Latency: a pixel is visible on the outputs exactly one cycle after the completing byte handshake (or after the FLUSH load).
- Output register:
  - Holds a stable value while out_valid && !out_ready.
  - out_valid clears on a consumed pixel with no new load in the same cycle.
  - Load and consume in the same cycle: the new pixel replaces the old one, and out_valid stays 1.
  - Full throughput: one pixel every 2 cycles with out_ready=1.
- Column tracking:
  - On each output load, out_col = counter and out_eol = (counter==LINE_PIXELS-1).
  - The counter then increments, wrapping to 0 after LINE_PIXELS-1.
  - A load with out_last=1 forces the counter to 0 for the next pixel.
- Field outputs are pure slices of out_data (no extra latency).
- err_clr and a set event in the same cycle: the set wins.

Optional Feature:
- Macro RGB565_EXPAND_EN.
- Defined:
  - Adds port out_rgb888, out, 24 bits, = {r8,g8,b8}.
  - r8={r,r[4:2]}, g8={g,g[5:4]}, b8={b,b[4:2]}.
  - Registered in the same cycle as out_data, stable under backpressure, reset 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- BYTE_ORDER=0, bytes 0x32 then 0x8C, out_ready=1 -> one cycle later out_data=0x8C32, out_r=0x11, out_g=0x21, out_b=0x12, out_col=0; with RGB565_EXPAND_EN, out_rgb888=0x8C8694.
- BYTE_ORDER=1, bytes 0xFF,0xFF, then 0x00,0x00 -> pixels 0xFFFF (r=0x1F,g=0x3F,b=0x1F, rgb888=0xFFFFFF) then 0x0000 (rgb888=0x000000).
- Backpressure: out_ready=0 for 3 cycles during a 4-byte stream 0x01..0x04 (BYTE_ORDER=0) -> first pixel 0x0201 held stable, in_ready=0 in SECOND; after release, 0x0403 follows, with no loss or duplication.
- Odd packet: single byte 0xAA with in_last=1 (BYTE_ORDER=0) -> out_data=0x00AA, out_last=1, err_odd=1 until err_clr pulse; next pair aligns fresh with out_col=0.
- LINE_PIXELS=4, 5 pixels streamed -> out_col 0,1,2,3,0 with out_eol=1 only on the 4th; a mid-line in_last pixel resets the next out_col to 0.
- Reset mid-operation: assert rst_n low after the first byte of a pair, then send 0x11,0x22 -> out_data=0x2211 (BYTE_ORDER=0), out_col=0, err_odd=0.

Source files
------------

// File: rtl/rgb565_byte_packer.sv
// ============================================================================
// Module   : rgb565_byte_packer
// Brief    : Packs an 8-bit byte stream into RGB565 pixel words with
//            valid/ready on both sides, line column tracking and odd-packet
//            flush. Optional RGB888 expansion output under RGB565_EXPAND_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rgb565_byte_packer #(
    parameter int BYTE_ORDER  = 0,
    parameter int LINE_PIXELS = 640,
    parameter int COL_W       = $clog2(LINE_PIXELS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [15:0]      out_data,
    output logic [4:0]       out_r,
    output logic [5:0]       out_g,
    output logic [4:0]       out_b,
    output logic [COL_W-1:0] out_col,
    output logic             out_eol,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef RGB565_EXPAND_EN
    output logic [23:0]      out_rgb888,
`endif
    output logic             err_odd,
    input  logic             err_clr
);

    localparam logic [1:0]       c_st_first  = 2'd0;
    localparam logic [1:0]       c_st_second = 2'd1;
    localparam logic [1:0]       c_st_flush  = 2'd2;
    localparam logic [COL_W-1:0] c_col_max   = COL_W'(LINE_PIXELS - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [7:0]       r_held;
    logic [15:0]      r_out_data;
    logic [COL_W-1:0] r_out_col;
    logic             r_out_eol;
    logic             r_out_last;
    logic             r_out_valid;
    logic             r_err_odd;
    logic [COL_W-1:0] r_col_cnt;
    logic             w_space;
    logic             w_in_ready;
    logic             w_load;
    logic             w_flush;
    logic             w_load_last;
    logic [15:0]      w_pair_word;
    logic [15:0]      w_odd_word;
    logic [15:0]      w_load_data;
    logic             w_col_wrap;

    assign w_space = !r_out_valid || out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_load      = 1'b0;
        w_flush     = 1'b0;
        w_load_last = 1'b0;
        case (r_state)
            c_st_first: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = in_last ? c_st_flush : c_st_second;
                end
            end
            c_st_second: begin
                w_in_ready = w_space;
                if (in_valid && w_space) begin
                    w_load      = 1'b1;
                    w_load_last = in_last;
                    w_state_nxt = c_st_first;
                end
            end
            c_st_flush: begin
                if (w_space) begin
                    w_load      = 1'b1;
                    w_flush     = 1'b1;
                    w_load_last = 1'b1;
                    w_state_nxt = c_st_first;
                end
            end
            default: w_state_nxt = c_st_first;
        endcase
    end

    // A lone trailing byte is padded with 0x00 in the slot of the missing byte.
    generate
        if (BYTE_ORDER == 0) begin : g_lsb_first
            assign w_pair_word = {in_data, r_held};
            assign w_odd_word  = {8'h00, r_held};
        end else begin : g_msb_first
            assign w_pair_word = {r_held, in_data};
            assign w_odd_word  = {r_held, 8'h00};
        end
    endgenerate

    assign w_load_data = w_flush ? w_odd_word : w_pair_word;
    assign w_col_wrap  = (r_col_cnt == c_col_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_first;
            r_held      <= 8'h00;
            r_out_data  <= 16'h0000;
            r_out_col   <= '0;
            r_out_eol   <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
            r_err_odd   <= 1'b0;
            r_col_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_st_first && in_valid) begin
                r_held <= in_data;
            end
            if (w_load) begin
                r_out_data  <= w_load_data;
                r_out_col   <= r_col_cnt;
                r_out_eol   <= w_col_wrap;
                r_out_last  <= w_load_last;
                r_out_valid <= 1'b1;
                // Packet end realigns the next pixel to column 0.
                r_col_cnt   <= (w_load_last || w_col_wrap) ? '0 : r_col_cnt + 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_flush) begin
                r_err_odd <= 1'b1;
            end else if (err_clr) begin
                r_err_odd <= 1'b0;
            end
        end
    end

`ifdef RGB565_EXPAND_EN
    logic [23:0] r_rgb888;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb888 <= 24'h000000;
        end else if (w_load) begin
            r_rgb888 <= {w_load_data[15:11], w_load_data[15:13],
                         w_load_data[10:5],  w_load_data[10:9],
                         w_load_data[4:0],   w_load_data[4:2]};
        end
    end

    assign out_rgb888 = r_rgb888;
`endif

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_r     = r_out_data[15:11];
    assign out_g     = r_out_data[10:5];
    assign out_b     = r_out_data[4:0];
    assign out_col   = r_out_col;
    assign out_eol   = r_out_eol;
    assign out_last  = r_out_last;
    assign out_valid = r_out_valid;
    assign err_odd   = r_err_odd;

endmodule

`default_nettype wire

// File: tb/tb_rgb565_byte_packer.sv
// ============================================================================
// Module   : tb_rgb565_byte_packer
// Brief    : Bench for rgb565_byte_packer; two instances (BYTE_ORDER 0/1,
//            LINE_PIXELS 4/5) share one stimulus stream against a pixel model.
//            Checks out_rgb888 too when RGB565_EXPAND_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rgb565_byte_packer;

    localparam int c_lp_a = 4;
    localparam int c_lp_b = 5;
    localparam int c_cw_a = $clog2(c_lp_a);
    localparam int c_cw_b = $clog2(c_lp_b);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] in_data = 8'h00;
    logic in_last = 1'b0, in_valid = 1'b0, out_ready = 1'b0, err_clr = 1'b0;

    logic in_ready_a, in_ready_b;
    logic [15:0] data_a, data_b;
    logic [4:0] r_a, r_b, b_a, b_b;
    logic [5:0] g_a, g_b;
    logic [c_cw_a-1:0] col_a;
    logic [c_cw_b-1:0] col_b;
    logic eol_a, eol_b, last_a, last_b, valid_a, valid_b, err_a, err_b;
    logic [23:0] rgb_a, rgb_b;

    rgb565_byte_packer #(.BYTE_ORDER(0), .LINE_PIXELS(c_lp_a)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready_a), .out_data(data_a),
        .out_r(r_a), .out_g(g_a), .out_b(b_a), .out_col(col_a), .out_eol(eol_a),
        .out_last(last_a), .out_valid(valid_a), .out_ready(out_ready),
`ifdef RGB565_EXPAND_EN
        .out_rgb888(rgb_a),
`endif
        .err_odd(err_a), .err_clr(err_clr));

    rgb565_byte_packer #(.BYTE_ORDER(1), .LINE_PIXELS(c_lp_b)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready_b), .out_data(data_b),
        .out_r(r_b), .out_g(g_b), .out_b(b_b), .out_col(col_b), .out_eol(eol_b),
        .out_last(last_b), .out_valid(valid_b), .out_ready(out_ready),
`ifdef RGB565_EXPAND_EN
        .out_rgb888(rgb_b),
`endif
        .err_odd(err_b), .err_clr(err_clr));

`ifndef RGB565_EXPAND_EN
    assign rgb_a = 24'h000000;
    assign rgb_b = 24'h000000;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the pixel currently presented by each instance.
    int c_bo[2] = '{0, 1};
    int c_lp[2] = '{c_lp_a, c_lp_b};
    bit m_have, m_pend, m_valid, m_last, m_err;
    int m_first, m_pkt_pix;
    int m_pix[2];
    int m_col[2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int mk_word(input int bo, input int first, input int second);
        return (bo == 0) ? second * 256 + first : first * 256 + second;
    endfunction

    function automatic int exp_888(input int p);
        int r, g, b;
        r = p / 2048;
        g = (p / 32) % 64;
        b = p % 32;
        return ((r * 8 + r / 4) * 65536) + ((g * 4 + g / 16) * 256) + (b * 8 + b / 4);
    endfunction

    task automatic model_load(input int second, input bit last);
        for (int i = 0; i < 2; i++) begin
            m_pix[i] = mk_word(c_bo[i], m_first, second);
            m_col[i] = m_pkt_pix % c_lp[i];
        end
        m_last    = last;
        m_pkt_pix = last ? 0 : m_pkt_pix + 1;
    endtask

    task automatic model_reset();
        m_have = 0; m_pend = 0; m_valid = 0; m_last = 0; m_err = 0;
        m_first = 0; m_pkt_pix = 0;
        for (int i = 0; i < 2; i++) begin
            m_pix[i] = 0;
            m_col[i] = 0;
        end
    endtask

    task automatic check_inst(input string n, input int i, input logic valid, input logic err,
                              input logic [15:0] d, input logic [4:0] r, input logic [5:0] g,
                              input logic [4:0] b, input int col, input logic eol,
                              input logic last, input logic [23:0] rgb);
        check_val({n, ".valid"}, 32'(valid), 32'(m_valid));
        check_val({n, ".err_odd"}, 32'(err), 32'(m_err));
        if (m_valid) begin
            check_val({n, ".data"}, 32'(d), m_pix[i]);
            check_val({n, ".r"}, 32'(r), m_pix[i] / 2048);
            check_val({n, ".g"}, 32'(g), (m_pix[i] / 32) % 64);
            check_val({n, ".b"}, 32'(b), m_pix[i] % 32);
            check_val({n, ".col"}, col, m_col[i]);
            check_val({n, ".eol"}, 32'(eol), 32'(m_col[i] == c_lp[i] - 1));
            check_val({n, ".last"}, 32'(last), 32'(m_last));
`ifdef RGB565_EXPAND_EN
            check_val({n, ".rgb888"}, 32'(rgb), exp_888(m_pix[i]));
`else
            if (rgb !== 24'h0) n_err += 0;
`endif
        end
    endtask

    task automatic check_outputs();
        check_inst("a", 0, valid_a, err_a, data_a, r_a, g_a, b_a, int'(col_a), eol_a, last_a, rgb_a);
        check_inst("b", 1, valid_b, err_b, data_b, r_b, g_b, b_b, int'(col_b), eol_b, last_b, rgb_b);
    endtask

    // One cycle: drive at the falling edge, predict, check after the next falling edge.
    task automatic step(input bit v, input logic [7:0] d, input bit l, input bit ordy, input bit clr);
        bit space, rdy, load, flush;
        in_valid = v; in_data = d; in_last = l; out_ready = ordy; err_clr = clr;
        #1;
        space = !m_valid || ordy;
        rdy   = m_pend ? 1'b0 : (m_have ? space : 1'b1);
        check_val("a.in_ready", 32'(in_ready_a), 32'(rdy));
        check_val("b.in_ready", 32'(in_ready_b), 32'(rdy));
        load = 0;
        flush = 0;
        if (m_pend) begin
            if (space) begin
                model_load(0, 1'b1);
                m_pend = 0; load = 1; flush = 1;
            end
        end else if (v && rdy) begin
            if (!m_have) begin
                m_first = int'(d);
                if (l) m_pend = 1; else m_have = 1;
            end else begin
                model_load(int'(d), l);
                m_have = 0; load = 1;
            end
        end
        if (load) m_valid = 1;
        else if (ordy) m_valid = 0;
        m_err = flush ? 1'b1 : (clr ? 1'b0 : m_err);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        in_valid = 0; out_ready = 0; err_clr = 0; in_last = 0;
        #1;
        check_val("a.rst_valid", 32'(valid_a), 32'h0);
        check_val("a.rst_data", 32'(data_a), 32'h0);
        check_val("b.rst_data", 32'(data_b), 32'h0);
        check_val("a.rst_col", 32'(col_a), 32'h0);
        check_val("a.rst_eol_last", 32'({eol_a, last_a}), 32'h0);
        check_val("a.rst_err", 32'(err_a), 32'h0);
        check_val("b.rst_valid_err", 32'({valid_b, err_b}), 32'h0);
        check_val("a.rst_in_ready", 32'(in_ready_a), 32'h1);
        check_val("a.rst_rgb888", 32'(rgb_a), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        do_reset();

        // Basic pair: 0x32, 0x8C.
        step(1, 8'h32, 0, 1, 0);
        step(1, 8'h8C, 0, 1, 0);
        check_val("a.pair_data", 32'(data_a), 32'h8C32);
        check_val("b.pair_data", 32'(data_b), 32'h328C);
        check_val("a.pair_col", 32'(col_a), 32'h0);
`ifdef RGB565_EXPAND_EN
        check_val("a.pair_rgb888", 32'(rgb_a), 32'h8C8694);
`endif

        // Extreme values.
        step(1, 8'hFF, 0, 1, 0);
        step(1, 8'hFF, 0, 1, 0);
        check_val("b.white", 32'(data_b), 32'hFFFF);
        step(1, 8'h00, 0, 1, 0);
        step(1, 8'h00, 0, 1, 0);
        check_val("b.black", 32'(data_b), 32'h0000);

        // Backpressure across a 4-byte stream.
        step(0, 8'h00, 0, 1, 0);
        step(1, 8'h01, 0, 1, 0);
        step(1, 8'h02, 0, 0, 0);
        check_val("a.bp_first", 32'(data_a), 32'h0201);
        step(1, 8'h03, 0, 0, 0);
        step(1, 8'h04, 0, 0, 0);
        check_val("a.bp_stall_hold", 32'(data_a), 32'h0201);
        step(1, 8'h04, 0, 1, 0);
        check_val("a.bp_second", 32'(data_a), 32'h0403);

        // Odd packet then sticky error and clear.
        step(0, 8'h00, 0, 1, 0);
        step(1, 8'hAA, 1, 1, 0);
        step(0, 8'h00, 0, 1, 0);
        check_val("a.odd_data", 32'(data_a), 32'h00AA);
        check_val("b.odd_data", 32'(data_b), 32'hAA00);
        check_val("a.odd_flags", 32'({last_a, err_a}), 32'h3);
        step(0, 8'h00, 0, 1, 1);
        check_val("a.err_cleared", 32'(err_a), 32'h0);
        step(1, 8'h10, 0, 1, 0);
        step(1, 8'h20, 0, 1, 0);
        check_val("a.realign_col", 32'(col_a), 32'h0);

        // Line wrap on instance a.
        for (int k = 0; k < 10; k++) step(1, 8'(k), 0, 1, 0);

        // Reset while holding the first byte of a pair.
        step(1, 8'h55, 0, 1, 0);
        do_reset();
        step(1, 8'h11, 0, 1, 0);
        step(1, 8'h22, 0, 1, 0);
        check_val("a.post_rst_data", 32'(data_a), 32'h2211);
        check_val("a.post_rst_col_err", 32'({col_a, err_a}), 32'h0);

        // Randomized traffic.
        for (int k = 0; k < 4000; k++) begin
            step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
